psg_wt_bus_master: RTL and testbench

- Downstream companion of the PSG wave-table bus arbiter.
- Consumes the arbiter's one-hot grant (sel) and owner index (seln), and runs one read cycle per grant on the system bus using the winning channel's address.
- Returns the read data to that channel and drives the arbiter's "bus transfer completed" input (arb_ack). Ownership changes only between bus cycles.

---
 rtl/psg_bus_pkg.sv | 25 ++
 rtl/psg_bus_watchdog.sv | 39 +++
 rtl/psg_wt_bus_master.sv | 132 +++++++++++++
 tb/tb_psg_wt_bus_master.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/psg_bus_pkg.sv
// ============================================================================
//  psg_bus_pkg
//  Shared types and constants for the PSG wave-table bus master.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package psg_bus_pkg;

    localparam int CH_NUM = 8;
    localparam int CH_W   = 3;
    localparam int DEF_AW = 24;
    localparam int DEF_DW = 16;
    localparam int WD_W   = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
        S_BUS  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/psg_bus_watchdog.sv
// ============================================================================
//  psg_bus_watchdog
//  Counts clocks spent in a bus cycle and flags expiry at TIMEOUT clocks.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module psg_bus_watchdog
    import psg_bus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // Expiry is seen on the TIMEOUT-th clock edge spent in the bus cycle.
    localparam logic [WD_W-1:0] c_LIMIT = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] r_cnt;

    assign expired = en && (r_cnt >= c_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && !expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/psg_wt_bus_master.sv
// ============================================================================
//  psg_wt_bus_master
//  Runs one system-bus read per arbiter grant and returns data to the owner.
//  Optional bus watchdog enabled by defining PSG_BUS_TIMEOUT_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module psg_wt_bus_master
    import psg_bus_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int NCH     = CH_NUM,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic [NCH-1:0]    req,
    input  logic [NCH*AW-1:0] adr_i,
    input  logic [NCH-1:0]    sel,
    input  logic [CH_W-1:0]   seln,
    output logic              arb_ack,
    output logic              cyc_o,
    output logic              stb_o,
    output logic [AW-1:0]     adr_o,
    input  logic              ack_i,
    input  logic [DW-1:0]     dat_i,
    output logic [NCH-1:0]    ch_ack,
    output logic [DW-1:0]     ch_dat
`ifdef PSG_BUS_TIMEOUT_EN
    ,
    output logic              bus_err
`endif
);

    state_t          r_state;
    logic [CH_W-1:0] r_chan;
    logic [AW-1:0]   w_adr [NCH];
    logic            w_expired;

    for (genvar k = 0; k < NCH; k++) begin : g_adr
        assign w_adr[k] = adr_i[k*AW +: AW];
    end

`ifdef PSG_BUS_TIMEOUT_EN
    psg_bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (r_state == S_ARB),
        .en      (r_state == S_BUS),
        .expired (w_expired)
    );
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
    assign w_expired        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_chan  <= '0;
            arb_ack <= 1'b1;
            cyc_o   <= 1'b0;
            stb_o   <= 1'b0;
            adr_o   <= '0;
            ch_ack  <= '0;
            ch_dat  <= '0;
`ifdef PSG_BUS_TIMEOUT_EN
            bus_err <= 1'b0;
`endif
        end else begin
            ch_ack <= '0;
`ifdef PSG_BUS_TIMEOUT_EN
            bus_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (ce && (|req)) begin
                        r_state <= S_ARB;
                        arb_ack <= 1'b0;
                    end
                end
                S_ARB: begin
                    // A grant is only honoured if the owner is still requesting.
                    if (sel[seln] && req[seln]) begin
                        r_chan  <= seln;
                        adr_o   <= w_adr[seln];
                        cyc_o   <= 1'b1;
                        stb_o   <= 1'b1;
                        r_state <= S_BUS;
                    end else begin
                        r_state <= S_IDLE;
                        arb_ack <= 1'b1;
                    end
                end
                S_BUS: begin
                    if (ack_i) begin
                        ch_dat         <= dat_i;
                        ch_ack[r_chan] <= 1'b1;
                        cyc_o          <= 1'b0;
                        stb_o          <= 1'b0;
                        r_state        <= S_DONE;
                    end else if (w_expired) begin
                        cyc_o   <= 1'b0;
                        stb_o   <= 1'b0;
`ifdef PSG_BUS_TIMEOUT_EN
                        bus_err <= 1'b1;
`endif
                        r_state <= S_IDLE;
                        arb_ack <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    arb_ack <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    arb_ack <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_psg_wt_bus_master.sv
// ============================================================================
//  tb_psg_wt_bus_master
//  Directed self-checking bench for psg_wt_bus_master with a simple arbiter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_psg_wt_bus_master;

    localparam int AW  = 24;
    localparam int DW  = 16;
    localparam int NCH = 8;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic              ce    = 1'b1;
    logic [NCH-1:0]    req   = '0;
    logic [NCH*AW-1:0] adr_i = '0;
    logic [NCH-1:0]    sel   = '0;
    logic [2:0]        seln  = '0;
    logic              ack_i = 1'b0;
    logic [DW-1:0]     dat_i = '0;
    logic              arb_ack;
    logic              cyc_o;
    logic              stb_o;
    logic [AW-1:0]     adr_o;
    logic [NCH-1:0]    ch_ack;
    logic [DW-1:0]     ch_dat;
`ifdef PSG_BUS_TIMEOUT_EN
    logic              bus_err;
`endif

    int vectors     = 0;
    int miscompares = 0;
    logic [DW-1:0] last_dat = '0;

    psg_wt_bus_master #(
        .AW      (AW),
        .DW      (DW),
        .NCH     (NCH),
        .TIMEOUT (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ce      (ce),
        .req     (req),
        .adr_i   (adr_i),
        .sel     (sel),
        .seln    (seln),
        .arb_ack (arb_ack),
        .cyc_o   (cyc_o),
        .stb_o   (stb_o),
        .adr_o   (adr_o),
        .ack_i   (ack_i),
        .dat_i   (dat_i),
        .ch_ack  (ch_ack),
        .ch_dat  (ch_dat)
`ifdef PSG_BUS_TIMEOUT_EN
        ,
        .bus_err (bus_err)
`endif
    );

    always #5 clk = ~clk;

    // Arbiter stand-in: lowest index wins, owner held when nothing requests.
    always @(posedge clk) begin
        if (ce && arb_ack && (|req)) begin
            for (int k = NCH - 1; k >= 0; k--) begin
                if (req[k]) begin
                    sel  <= 8'b1 << k;
                    seln <= 3'(k);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_adr(input int ch, input logic [AW-1:0] a);
        adr_i[ch*AW +: AW] = a;
    endtask

    task automatic wait_cyc(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cyc_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Waits for the bus cycle, acks after wait_clks BUS clocks, checks DONE/IDLE.
    task automatic service(input int ch, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input int wait_clks);
        logic ok;
        wait_cyc(ok);
        check("cyc_start", 32'(ok), 32'd1);
        check("adr_o", 32'(adr_o), 32'(a));
        check("stb_o", 32'(stb_o), 32'd1);
        check("arb_ack_bus", 32'(arb_ack), 32'd0);
        for (int i = 0; i < wait_clks; i++) begin
            tick();
            check("cyc_hold", 32'(cyc_o), 32'd1);
            check("adr_hold", 32'(adr_o), 32'(a));
        end
        ack_i = 1'b1;
        dat_i = d;
        tick();
        ack_i = 1'b0;
        dat_i = '0;
        check("ch_ack_done", 32'(ch_ack), 32'(8'b1 << ch));
        check("ch_dat_done", 32'(ch_dat), 32'(d));
        check("cyc_done", 32'(cyc_o), 32'd0);
`ifdef PSG_BUS_TIMEOUT_EN
        check("bus_err_done", 32'(bus_err), 32'd0);
`endif
        last_dat = d;
        req[ch]  = 1'b0;
        tick();
        check("ch_ack_idle", 32'(ch_ack), 32'd0);
        check("arb_ack_idle", 32'(arb_ack), 32'd1);
        check("ch_dat_hold", 32'(ch_dat), 32'(d));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic ok;
        set_adr(0, 24'h00D000);
        set_adr(1, 24'h00E001);
        set_adr(2, 24'h00A002);
        set_adr(3, 24'h001234);
        set_adr(5, 24'h00B005);
        set_adr(7, 24'h00C007);

        // Reset values
        #2 rst_n = 1'b0;
        tick();
        tick();
        check("rst_arb_ack", 32'(arb_ack), 32'd1);
        check("rst_cyc", 32'(cyc_o), 32'd0);
        check("rst_stb", 32'(stb_o), 32'd0);
        check("rst_adr", 32'(adr_o), 32'd0);
        check("rst_ch_ack", 32'(ch_ack), 32'd0);
        check("rst_ch_dat", 32'(ch_dat), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single request from channel 3
        req = 8'h08;
        service(3, 24'h001234, 16'hBEEF, 2);

        // Reset asserted in the middle of a bus cycle
        req = 8'h08;
        wait_cyc(ok);
        check("mid_cyc_start", 32'(ok), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_cyc", 32'(cyc_o), 32'd0);
        check("mid_rst_arb_ack", 32'(arb_ack), 32'd1);
        check("mid_rst_ch_ack", 32'(ch_ack), 32'd0);
        check("mid_rst_adr", 32'(adr_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        service(3, 24'h001234, 16'h1357, 1);

        // Priority: ch2 before ch5, no overlap
        req = 8'h24;
        service(2, 24'h00A002, 16'h2222, 1);
        check("prio_gap_cyc", 32'(cyc_o), 32'd0);
        service(5, 24'h00B005, 16'h5555, 0);

        // Stale owner: request drops before ARB
        req = 8'h02;
        tick();
        check("stale_arb", 32'(arb_ack), 32'd0);
        req = 8'h00;
        tick();
        check("stale_idle", 32'(arb_ack), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("stale_cyc", 32'(cyc_o), 32'd0);
            check("stale_ch_ack", 32'(ch_ack), 32'd0);
            tick();
        end
        check("stale_ch_dat", 32'(ch_dat), 32'(last_dat));

        // ce gating: idle until ce, then complete with ce low
        @(negedge clk);
        ce  = 1'b0;
        req = 8'h80;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ce_idle_arb_ack", 32'(arb_ack), 32'd1);
            check("ce_idle_cyc", 32'(cyc_o), 32'd0);
        end
        ce = 1'b1;
        tick();
        check("ce_arb", 32'(arb_ack), 32'd0);
        ce = 1'b0;
        service(7, 24'h00C007, 16'h7A7A, 2);
        ce = 1'b1;

        // Stray ack outside a bus cycle is ignored
        ack_i = 1'b1;
        dat_i = 16'hDEAD;
        tick();
        tick();
        ack_i = 1'b0;
        dat_i = '0;
        check("stray_ch_ack", 32'(ch_ack), 32'd0);
        check("stray_ch_dat", 32'(ch_dat), 32'(last_dat));

`ifdef PSG_BUS_TIMEOUT_EN
        // No ack: bus_err after 4 BUS clocks
        req = 8'h01;
        wait_cyc(ok);
        check("to_cyc_start", 32'(ok), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_cyc_hold", 32'(cyc_o), 32'd1);
            check("to_no_err", 32'(bus_err), 32'd0);
        end
        tick();
        check("to_bus_err", 32'(bus_err), 32'd1);
        check("to_cyc_drop", 32'(cyc_o), 32'd0);
        check("to_ch_ack", 32'(ch_ack), 32'd0);
        check("to_ch_dat", 32'(ch_dat), 32'(last_dat));
        req = 8'h00;
        tick();
        check("to_err_pulse", 32'(bus_err), 32'd0);
        check("to_arb_ack", 32'(arb_ack), 32'd1);

        // Ack on the 4th BUS clock wins over the timeout
        req = 8'h01;
        service(0, 24'h00D000, 16'h5A5A, 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
